// File: rtl/seg_display_arbiter_if.sv
// Bundle of request, digit-data and display signals shared by the seven-segment
// display arbiter and whoever drives its requesters.
interface seg_display_arbiter_if;
  logic [2:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [3:0]  mode0;
  logic [3:0]  mode1;
  logic [3:0]  mode2;
  logic [2:0]  gnt;
  logic [3:0]  mode;
  logic [3:0]  num0;
  logic [3:0]  num1;
  logic [3:0]  num2;
  logic [3:0]  num3;
  logic        busy;

  modport master (
    output req, data0, data1, data2, mode0, mode1, mode2,
    input  gnt, mode, num0, num1, num2, num3, busy
  );

  modport slave (
    input  req, data0, data1, data2, mode0, mode1, mode2,
    output gnt, mode, num0, num1, num2, num3, busy
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Fixed-priority arbiter that hands one of three requesters the seven-segment
// display, holding each grant for a minimum number of cycles before release.
module seg_display_arbiter #(
  parameter int unsigned HOLD_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg_display_arbiter_if.slave bus
);

  localparam logic [1:0]  OWN_R0      = 2'd0;
  localparam logic [1:0]  OWN_R1      = 2'd1;
  localparam logic [1:0]  OWN_R2      = 2'd2;
  localparam logic [1:0]  OWN_NONE    = 2'd3;
  localparam logic [15:0] HOLD_RELOAD = 16'(HOLD_CYC - 1);

  logic [1:0]  owner_p1;
  logic [15:0] hold_p1;
  logic        frozen_p1;

  logic [1:0]  owner_p0;
  logic [15:0] hold_p0;
  logic        frozen_p0;
  logic        load_p0;
  logic [1:0]  sel_p0;
  logic [1:0]  top_req;
  logic        any_req;
  logic        own_req;
  logic        higher_req;
  logic [15:0] sel_data;
  logic [3:0]  sel_mode;

  // Unsupported display modes collapse to mode 0.
  function automatic logic [3:0] sat_mode(input logic [3:0] m);
    return (m > 4'd2) ? 4'd0 : m;
  endfunction

  function automatic logic [2:0] to_onehot(input logic [1:0] own);
    case (own)
      OWN_R0:  return 3'b001;
      OWN_R1:  return 3'b010;
      OWN_R2:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always_comb begin
    any_req = |bus.req;
    if (bus.req[2])      top_req = OWN_R2;
    else if (bus.req[1]) top_req = OWN_R1;
    else                 top_req = OWN_R0;

    case (owner_p1)
      OWN_R0:  begin own_req = bus.req[0]; higher_req = |bus.req[2:1]; end
      OWN_R1:  begin own_req = bus.req[1]; higher_req = bus.req[2];    end
      OWN_R2:  begin own_req = bus.req[2]; higher_req = 1'b0;          end
      default: begin own_req = 1'b0;       higher_req = 1'b0;          end
    endcase
  end

  // Stage p0: next ownership, hold count and output load decision.
  always_comb begin
    owner_p0  = owner_p1;
    hold_p0   = (hold_p1 != 16'd0) ? hold_p1 - 16'd1 : 16'd0;
    frozen_p0 = frozen_p1;
    load_p0   = 1'b0;
    sel_p0    = owner_p1;

    if ((owner_p1 == OWN_NONE && any_req) || higher_req) begin
      owner_p0  = top_req;
      hold_p0   = HOLD_RELOAD;
      frozen_p0 = 1'b0;
      load_p0   = 1'b1;
      sel_p0    = top_req;
    end else if (owner_p1 != OWN_NONE) begin
      if (own_req) begin
        frozen_p0 = 1'b0;
        load_p0   = 1'b1;
      end else if (hold_p1 != 16'd0) begin
        frozen_p0 = 1'b1;
      end else if (any_req) begin
        // Hand over on the release edge itself so the display never idles.
        owner_p0  = top_req;
        hold_p0   = HOLD_RELOAD;
        frozen_p0 = 1'b0;
        load_p0   = 1'b1;
        sel_p0    = top_req;
      end else begin
        owner_p0  = OWN_NONE;
        frozen_p0 = 1'b0;
      end
    end
  end

  always_comb begin
    case (sel_p0)
      OWN_R1:  begin sel_data = bus.data1; sel_mode = bus.mode1; end
      OWN_R2:  begin sel_data = bus.data2; sel_mode = bus.mode2; end
      default: begin sel_data = bus.data0; sel_mode = bus.mode0; end
    endcase
  end

  // Stage p1: registered state and display outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_p1  <= OWN_NONE;
      hold_p1   <= 16'd0;
      frozen_p1 <= 1'b0;
      bus.gnt   <= 3'b000;
      bus.busy  <= 1'b0;
      bus.mode  <= 4'd0;
      bus.num0  <= 4'd0;
      bus.num1  <= 4'd0;
      bus.num2  <= 4'd0;
      bus.num3  <= 4'd0;
    end else begin
      owner_p1  <= owner_p0;
      hold_p1   <= hold_p0;
      frozen_p1 <= frozen_p0;
      bus.gnt   <= to_onehot(owner_p0);
      bus.busy  <= (hold_p0 != 16'd0);
      if (load_p0) begin
        bus.mode <= sat_mode(sel_mode);
        bus.num0 <= sel_data[3:0];
        bus.num1 <= sel_data[7:4];
        bus.num2 <= sel_data[11:8];
        bus.num3 <= sel_data[15:12];
      end
    end
  end

endmodule

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 Parameter HOLD_CYC, default 1000, minimum clk cycles a grant is held before release by its owner; range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  3  request levels; bit 2 highest priority, bit 0 lowest.
REQ-005 data0, data1, data2  input  16 each  digit nibbles for requester i, packed {num3,num2,num1,num0}.
REQ-006 mode0, mode1, mode2  input  4 each  display mode for requester i.
REQ-007 gnt  output  3  one-hot grant, or all-zero when no owner.
REQ-008 mode  output  4  mode to the seven-segment driver.
REQ-009 num0, num1, num2, num3  output  4 each  digit values to the seven-segment driver.
REQ-010 busy  output  1  high while hold_cnt is non-zero.

Function
REQ-011 All outputs shall be registered.
REQ-012 Internal state: owner (NONE, R0, R1, R2), 16-bit hold_cnt, frozen flag.
REQ-013 owner NONE, any req bit high at edge N: owner becomes highest-priority requester at edge N, so gnt and outputs reflect it in cycle N+1; hold_cnt loads HOLD_CYC-1.
REQ-014 While owner's req is high and frozen clear, num0..num3 and mode shall track owner's data/mode with one-cycle latency.
REQ-015 Mode input values greater than 2 shall be output as 0.
REQ-016 hold_cnt shall decrement by 1 each cycle while non-zero and saturate at 0.
REQ-017 Preemption: a req bit of higher priority than owner shall take ownership at the next edge regardless of hold_cnt, reloading hold_cnt to HOLD_CYC-1 and clearing frozen.
REQ-018 Owner drops req while hold_cnt is non-zero: frozen shall set; outputs hold last values; gnt stays asserted until hold_cnt is 0.
REQ-019 Owner re-asserts req while frozen and hold_cnt is non-zero: frozen shall clear and tracking resumes; hold_cnt is not reloaded.
REQ-020 Release happens when hold_cnt is 0 and owner's req is low.
REQ-021 At release, if another req bit is high, the highest-priority one shall be granted at the same edge (no idle cycle), with hold_cnt reloaded.
REQ-022 At release, if no req bit is high, owner shall become NONE and gnt shall become 0; num0..num3 and mode shall keep their last values.
REQ-023 Owner holding req after hold expiry keeps ownership indefinitely; only higher priority (REQ-017) or release (REQ-020) changes it.
REQ-024 Lower-priority requests shall never preempt; requests are not queued beyond their level.
REQ-025 gnt shall never have more than one bit set.

Reset
REQ-026 At any rising edge with rst_n low, set owner NONE, gnt 0, hold_cnt 0, frozen 0, busy 0, mode 0, num0..num3 0.
REQ-027 Reset mid-grant shall abort the grant with no output glitch beyond the reset values.
REQ-028 The first grant after rst_n returns high follows REQ-013.

Verification
REQ-029 Reset, then req=001, data0=16'h1234, mode0=0: cycle after assertion gnt=001, num3..num0=1,2,3,4, mode=0, busy=1.
REQ-030 HOLD_CYC=4; R0 owns, req=011 at cycle 1: next cycle gnt=010, outputs show data1; R0 regains only after R1 drops req and 4 cycles elapse since R1's grant.
REQ-031 HOLD_CYC=8; R1 owns, drops req at cycle 2, data1 changes to 16'hFFFF: outputs stay at the pre-drop value, gnt=010 until hold_cnt=0, then gnt=000.
REQ-032 Release with req=001 pending at the same edge: gnt goes 010->001 in one cycle with no 000 cycle; hold_cnt reloads.
REQ-033 mode2=4'd7 granted: mode output=0. rst_n low for one cycle mid-grant: all outputs zero the next cycle.
